// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg
//   Shared types and constants for the UART TX line arbiter.
//   t_uarttx_arb_state : arbiter FSM state (IDLE -> SEND -> DONE -> IDLE)
//   c_line_bytes       : default bytes per ASCII line
//   c_line_of_spaces   : idle line image, all spaces terminated by CR LF
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_ARB_IDLE = 2'd0,
        ST_ARB_SEND = 2'd1,
        ST_ARB_DONE = 2'd2
    } t_uarttx_arb_state;

    localparam int unsigned c_line_bytes = 34;

    localparam logic [c_line_bytes*8-1:0] c_line_of_spaces =
        {{(c_line_bytes - 2){8'h20}}, 8'h0D, 8'h0A};

endpackage

// File: rtl/uart_tx_line_arbiter_if.sv
// uart_tx_line_arbiter_if
//   Bundles the producer request/line/ack/done signals and the byte stream towards the TX FIFO.
//   Signal prefixes are from the arbiter's point of view.
//   i_req       : level request per producer
//   i_line_flat : producer k line at bits [(k+1)*L*8-1 -: L*8]
//   o_ack       : one-cycle pulse, line captured
//   o_done      : one-cycle pulse, last byte accepted by the FIFO
//   o_tx_data / o_tx_valid / i_tx_ready : byte handshake into the FIFO
//   o_busy      : arbiter not idle
//   o_grant_idx : current / last grantee
//   modport master : arbiter side; modport slave : producers + FIFO side
interface uart_tx_line_arbiter_if #(
    parameter int unsigned parm_N_REQ      = 3,
    parameter int unsigned parm_LINE_BYTES = 34
);
    logic [parm_N_REQ-1:0]                   i_req;
    logic [parm_N_REQ*parm_LINE_BYTES*8-1:0] i_line_flat;
    logic [parm_N_REQ-1:0]                   o_ack;
    logic [parm_N_REQ-1:0]                   o_done;
    logic [7:0]                              o_tx_data;
    logic                                    o_tx_valid;
    logic                                    i_tx_ready;
    logic                                    o_busy;
    logic [$clog2(parm_N_REQ)-1:0]           o_grant_idx;

    modport master (
        input  i_req, i_line_flat, i_tx_ready,
        output o_ack, o_done, o_tx_data, o_tx_valid, o_busy, o_grant_idx
    );

    modport slave (
        output i_req, i_line_flat, i_tx_ready,
        input  o_ack, o_done, o_tx_data, o_tx_valid, o_busy, o_grant_idx
    );
endinterface

// File: rtl/rr_priority_pick.sv
// rr_priority_pick
//   Combinational round-robin selector: returns the first set request found when searching
//   i_ptr+1, i_ptr+2, ... modulo N.
//   i_req : request vector
//   i_ptr : index of the most recent grantee (lowest priority)
//   o_any : at least one request is set
//   o_idx : selected index (0 when o_any is low)
module rr_priority_pick #(
    parameter  int unsigned N = 3,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic         o_any,
    output logic [W-1:0] o_idx
);

    logic [W-1:0] w_pos;

    always_comb begin
        o_any = |i_req;
        o_idx = '0;
        w_pos = '0;
        // Scan from farthest to nearest so the final hit is the nearest one after the pointer.
        for (int i = int'(N); i >= 1; i--) begin
            w_pos = W'((int'(i_ptr) + i) % int'(N));
            if (i_req[w_pos]) begin
                o_idx = w_pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_line_arbiter.sv
// uart_tx_line_arbiter
//   Shares one UART TX FIFO between parm_N_REQ line producers. A round-robin winner's line is
//   captured, acknowledged, and streamed MSB byte first with a valid/ready handshake; the
//   producer gets a done pulse once the last byte is accepted.
//   i_clk_20mhz   : system clock
//   i_rst_20mhz_n : synchronous active-low reset
//   if_arb        : producer and FIFO signals (see uart_tx_line_arbiter_if)
module uart_tx_line_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned parm_N_REQ      = 3,
    parameter int unsigned parm_LINE_BYTES = c_line_bytes
) (
    input  logic                   i_clk_20mhz,
    input  logic                   i_rst_20mhz_n,
    uart_tx_line_arbiter_if.master if_arb
);

    localparam int unsigned c_w  = $clog2(parm_N_REQ);
    localparam int unsigned c_cw = $clog2(parm_LINE_BYTES + 1);
    localparam int unsigned c_lw = parm_LINE_BYTES * 8;

    localparam logic [c_lw-1:0] c_reset_line = {{(parm_LINE_BYTES - 2){8'h20}}, 8'h0D, 8'h0A};

    t_uarttx_arb_state r_state, w_state_nxt;
    logic [c_w-1:0]    r_grant, w_grant_nxt;
    logic [c_w-1:0]    r_ptr, w_ptr_nxt;
    logic [c_cw-1:0]   r_count, w_count_nxt;
    logic [c_lw-1:0]   r_line, w_line_nxt;
    logic              r_first, w_first_nxt;

    logic              w_any;
    logic [c_w-1:0]    w_pick;
    logic [c_lw-1:0]   w_sel_line;
    logic [parm_N_REQ-1:0] w_grant_onehot;

    rr_priority_pick #(
        .N (parm_N_REQ)
    ) u_pick (
        .i_req (if_arb.i_req),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_pick)
    );

    assign w_sel_line     = c_lw'(if_arb.i_line_flat >> (int'(w_pick) * int'(c_lw)));
    assign w_grant_onehot = parm_N_REQ'(1) << r_grant;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_count_nxt = r_count;
        w_line_nxt  = r_line;
        w_first_nxt = r_first;
        unique case (r_state)
            ST_ARB_IDLE: begin
                if (w_any) begin
                    w_grant_nxt = w_pick;
                    w_ptr_nxt   = w_pick;
                    w_line_nxt  = w_sel_line;
                    w_count_nxt = c_cw'(parm_LINE_BYTES);
                    w_first_nxt = 1'b1;
                    w_state_nxt = ST_ARB_SEND;
                end
            end
            ST_ARB_SEND: begin
                w_first_nxt = 1'b0;
                // o_tx_valid is constantly high here, so ready alone marks a transfer.
                if (if_arb.i_tx_ready) begin
                    w_line_nxt  = r_line << 8;
                    w_count_nxt = r_count - c_cw'(1);
                    if (r_count == c_cw'(1)) begin
                        w_state_nxt = ST_ARB_DONE;
                    end
                end
            end
            ST_ARB_DONE: begin
                w_state_nxt = ST_ARB_IDLE;
            end
            default: begin
                w_state_nxt = ST_ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (!i_rst_20mhz_n) begin
            r_state <= ST_ARB_IDLE;
            r_grant <= '0;
            // Pointer at N-1 so producer 0 is searched first after reset.
            r_ptr   <= c_w'(parm_N_REQ - 1);
            r_count <= '0;
            r_line  <= c_reset_line;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_count <= w_count_nxt;
            r_line  <= w_line_nxt;
            r_first <= w_first_nxt;
        end
    end

    // Outputs decode registered state only, so they are glitch-free.
    always_comb begin
        if_arb.o_ack       = '0;
        if_arb.o_done      = '0;
        if_arb.o_tx_valid  = 1'b0;
        if_arb.o_tx_data   = '0;
        if_arb.o_busy      = (r_state != ST_ARB_IDLE);
        if_arb.o_grant_idx = r_grant;
        if (r_state == ST_ARB_SEND) begin
            if_arb.o_tx_valid = 1'b1;
            if_arb.o_tx_data  = r_line[c_lw-1 -: 8];
            if (r_first) begin
                if_arb.o_ack = w_grant_onehot;
            end
        end
        if (r_state == ST_ARB_DONE) begin
            if_arb.o_done = w_grant_onehot;
        end
    end

endmodule

// File: tb/tb_uart_tx_line_arbiter.sv
// tb_uart_tx_line_arbiter
//   Scoreboard bench: a transaction-level model pushes expected grants, line bytes and done
//   events into queues at each grant; a monitor pops and compares whenever the DUT shows an
//   ack, a byte transfer or a done pulse.
module tb_uart_tx_line_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned L  = 34;
    localparam int unsigned LW = L * 8;

    localparam int P_HOLD    = 1;
    localparam int P_ONESHOT = 2;
    localparam int P_REARM   = 3;

    localparam int R_ALWAYS  = 0;
    localparam int R_PATTERN = 1;
    localparam int R_RANDOM  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #25 clk = ~clk;

    uart_tx_line_arbiter_if #(.parm_N_REQ(N), .parm_LINE_BYTES(L)) bus_if ();

    uart_tx_line_arbiter #(
        .parm_N_REQ      (N),
        .parm_LINE_BYTES (L)
    ) dut (
        .i_clk_20mhz   (clk),
        .i_rst_20mhz_n (rst_n),
        .if_arb        (bus_if)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    int unsigned exp_grant_q[$];
    logic [7:0]  exp_byte_q[$];
    int unsigned exp_done_q[$];
    int unsigned obs_grants[$];

    int ack_cyc        = -10;
    int xfer_since_ack = 0;
    int done_cyc [N];
    int pmode    [N];
    int rmode      = R_ALWAYS;
    int pat_i      = 0;
    bit gen_random = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        v = '0;
        for (int i = 0; i < int'(L) - 2; i++) v = {v[LW-9:0], 8'($urandom_range(32, 126))};
        return {v[LW-17:0], 8'h0D, 8'h0A};
    endfunction

    task automatic set_line(input int k, input logic [LW-1:0] v);
        for (int b = 0; b < int'(LW); b++) bus_if.i_line_flat[k*LW + b] = v[b];
    endtask

    // ---------------- reference model: one grant = one transaction ----------------
    initial begin : model
        int          phase;
        int          left;
        int unsigned ptr;
        int unsigned win;
        logic [LW-1:0] ln;
        phase = 0;
        left  = 0;
        ptr   = N - 1;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                phase = 0;
                ptr   = N - 1;
                exp_grant_q.delete();
                exp_byte_q.delete();
                exp_done_q.delete();
            end else begin
                case (phase)
                    0: if (bus_if.i_req != 0) begin
                        win = ptr;
                        for (int i = 1; i <= int'(N); i++) begin
                            if (bus_if.i_req[(ptr + i) % N]) begin
                                win = (ptr + i) % N;
                                break;
                            end
                        end
                        ptr = win;
                        ln  = LW'(bus_if.i_line_flat >> (win * LW));
                        exp_grant_q.push_back(win);
                        for (int b = 0; b < int'(L); b++) begin
                            exp_byte_q.push_back(ln[LW-1 -: 8]);
                            ln = ln << 8;
                        end
                        exp_done_q.push_back(win);
                        left  = L;
                        phase = 1;
                    end
                    1: if (bus_if.i_tx_ready) begin
                        left--;
                        if (left == 0) phase = 2;
                    end
                    default: phase = 0;
                endcase
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic        pv;
        logic        pr;
        logic [7:0]  pd;
        int unsigned g;
        logic [7:0]  eb;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus_if.o_ack != 0) begin
                    if (exp_grant_q.size() == 0) fail_now("ack_unexpected");
                    else begin
                        g = exp_grant_q.pop_front();
                        chk("ack_onehot", bus_if.o_ack, 64'(1) << g);
                        chk("grant_idx", bus_if.o_grant_idx, g);
                    end
                    obs_grants.push_back(int'(bus_if.o_grant_idx));
                    ack_cyc        = cyc;
                    xfer_since_ack = 0;
                end
                if (pv && !pr) begin
                    chk("valid_hold", bus_if.o_tx_valid, 1);
                    chk("data_hold", bus_if.o_tx_data, pd);
                end
                if (bus_if.o_tx_valid && bus_if.i_tx_ready) begin
                    if (exp_byte_q.size() == 0) fail_now("byte_unexpected");
                    else begin
                        eb = exp_byte_q.pop_front();
                        chk("tx_byte", bus_if.o_tx_data, eb);
                    end
                    xfer_since_ack++;
                end
                if (bus_if.o_done != 0) begin
                    chk("done_excl_ack", bus_if.o_ack, 0);
                    if (exp_done_q.size() == 0) fail_now("done_unexpected");
                    else begin
                        g = exp_done_q.pop_front();
                        chk("done_onehot", bus_if.o_done, 64'(1) << g);
                        chk("bytes_per_line", xfer_since_ack, L);
                        done_cyc[g] = cyc;
                    end
                end
                pv = bus_if.o_tx_valid;
                pr = bus_if.i_tx_ready;
                pd = bus_if.o_tx_data;
            end else begin
                pv = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < int'(N); k++) begin
            if (pmode[k] == P_ONESHOT && done_cyc[k] == cyc - 1) bus_if.i_req[k] = 1'b0;
            if (pmode[k] == P_REARM) begin
                if (done_cyc[k] == cyc - 1) bus_if.i_req[k] = 1'b0;
                if (done_cyc[k] == cyc - 2) bus_if.i_req[k] = 1'b1;
            end
        end
        case (rmode)
            R_PATTERN: begin
                bus_if.i_tx_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
                pat_i++;
            end
            R_RANDOM: bus_if.i_tx_ready = ($urandom_range(0, 3) != 0);
            default:  bus_if.i_tx_ready = 1'b1;
        endcase
        if (gen_random) begin
            for (int k = 0; k < int'(N); k++) begin
                if ($urandom_range(0, 15) == 0) set_line(k, rand_line());
                if (!bus_if.i_req[k] && done_cyc[k] < cyc - 1 && $urandom_range(0, 7) == 0) begin
                    bus_if.i_req[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_grants(input int target, input int budget);
        int n;
        n = 0;
        while (obs_grants.size() < target && n < budget) begin
            tick();
            n++;
        end
        if (obs_grants.size() < target) fail_now("timeout_waiting_grant");
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((bus_if.i_req != 0 || bus_if.o_busy) && n < budget) begin
            tick();
            n++;
        end
        if (bus_if.i_req != 0 || bus_if.o_busy) fail_now("timeout_waiting_idle");
        repeat (2) tick();
    endtask

    initial begin : watchdog
        #(50 * 90000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int            t;
        int            g0;
        int            n;
        int            d_before;
        string         s;
        logic [LW-1:0] acl;

        bus_if.i_req       = '0;
        bus_if.i_line_flat = '0;
        bus_if.i_tx_ready  = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            pmode[k]    = P_ONESHOT;
            done_cyc[k] = -10;
        end

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", bus_if.o_busy, 0);
        chk("rst_valid", bus_if.o_tx_valid, 0);
        chk("rst_ack", bus_if.o_ack, 0);
        chk("rst_done", bus_if.o_done, 0);
        chk("rst_grant", bus_if.o_grant_idx, 0);
        chk("rst_data", bus_if.o_tx_data, 0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: single request, exact latency
        s   = "ACL X+0000 Y-0012 Z+1000 T0001  ";
        acl = '0;
        for (int i = 0; i < int'(L) - 2; i++) acl = {acl[LW-9:0], (i < s.len()) ? s[i] : 8'h20};
        acl = {acl[LW-17:0], 8'h0D, 8'h0A};
        rmode = R_ALWAYS;
        bus_if.i_tx_ready = 1'b1;
        set_line(0, acl);
        bus_if.i_req[0] = 1'b1;
        t = cyc;
        tick();
        @(negedge clk);
        chk("t1_ack_at_t1", bus_if.o_ack, 3'b001);
        chk("t1_first_byte", bus_if.o_tx_data, 8'h41);
        n = 0;
        while (done_cyc[0] <= t && n < 60) begin
            tick();
            n++;
        end
        chk("t1_ack_cycle", ack_cyc, t + 1);
        chk("t1_done_cycle", done_cyc[0], t + 35);
        while (cyc < t + 36) tick();
        @(negedge clk);
        chk("t1_idle_after_done", bus_if.o_busy, 0);
        wait_idle(100);

        // 2: backpressure 1,0,0,1
        rmode = R_PATTERN;
        pat_i = 0;
        set_line(1, rand_line());
        bus_if.i_req[1] = 1'b1;
        wait_idle(300);

        // 4: line changed the cycle after ack
        rmode = R_RANDOM;
        set_line(2, rand_line());
        bus_if.i_req[2] = 1'b1;
        g0 = obs_grants.size();
        wait_grants(g0 + 1, 20);
        set_line(2, rand_line());
        wait_idle(300);

        // 3: contention with re-assertion after each done
        for (int k = 0; k < int'(N); k++) begin
            set_line(k, rand_line());
            pmode[k] = P_REARM;
        end
        g0 = obs_grants.size();
        bus_if.i_req = '1;
        wait_grants(g0 + 6, 600);
        for (int k = 0; k < int'(N); k++) pmode[k] = P_ONESHOT;
        wait_idle(600);
        if (obs_grants.size() >= g0 + 6) begin
            for (int i = 0; i < 6; i++) chk("t3_rr_order", obs_grants[g0 + i], i % 3);
        end

        // 6: request held through done
        rmode    = R_ALWAYS;
        pmode[0] = P_HOLD;
        set_line(0, rand_line());
        g0 = obs_grants.size();
        bus_if.i_req[0] = 1'b1;
        wait_grants(g0 + 2, 100);
        set_line(2, rand_line());
        bus_if.i_req[2] = 1'b1;
        wait_grants(g0 + 4, 200);
        pmode[0] = P_ONESHOT;
        wait_idle(200);
        if (obs_grants.size() >= g0 + 4) begin
            chk("t6_grant0", obs_grants[g0], 0);
            chk("t6_grant1", obs_grants[g0 + 1], 0);
            chk("t6_grant2", obs_grants[g0 + 2], 2);
            chk("t6_grant3", obs_grants[g0 + 3], 0);
        end

        // 5: reset in the middle of a line
        set_line(0, rand_line());
        bus_if.i_req[0] = 1'b1;
        g0 = obs_grants.size();
        wait_grants(g0 + 1, 20);
        n = 0;
        while (xfer_since_ack < 10 && n < 40) begin
            tick();
            n++;
        end
        d_before = done_cyc[0];
        rst_n = 1'b0;
        bus_if.i_req = '0;
        tick();
        @(negedge clk);
        chk("t5_valid_low", bus_if.o_tx_valid, 0);
        chk("t5_busy_low", bus_if.o_busy, 0);
        chk("t5_ack_low", bus_if.o_ack, 0);
        chk("t5_done_low", bus_if.o_done, 0);
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("t5_no_done_pulse", done_cyc[0], d_before);
        set_line(0, rand_line());
        set_line(1, rand_line());
        bus_if.i_req[0] = 1'b1;
        bus_if.i_req[1] = 1'b1;
        g0 = obs_grants.size();
        wait_grants(g0 + 1, 20);
        if (obs_grants.size() > g0) chk("t5_ptr_reset", obs_grants[g0], 0);
        wait_idle(300);

        // Randomized traffic
        rmode      = R_RANDOM;
        gen_random = 1'b1;
        repeat (1500) tick();
        gen_random = 1'b0;
        wait_idle(1000);

        chk("queues_drained", exp_byte_q.size() + exp_grant_q.size() + exp_done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
